// File: rtl/alu_ex_stage.sv
// Execute-stage front end: registers decoded instructions (D), drives the external ALU
// from them, and registers writeback/redirect results (R) behind a valid/ready output.
module alu_ex_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_kind,
   input  logic [2:0]      in_funct3,
   input  logic            in_funct7b5,
   input  logic [4:0]      in_rd,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [XLEN-1:0] in_imm,
   output logic [XLEN-1:0] alu_s1,
   output logic [XLEN-1:0] alu_s2,
   output logic [2:0]      alu_op,
   output logic            alu_sub,
   output logic            alu_sra,
   input  logic [XLEN-1:0] alu_out,
   input  logic            alu_eq,
   input  logic            alu_lt,
   input  logic            alu_ltu,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      out_rd,
   output logic            out_we,
   output logic [XLEN-1:0] out_result,
   output logic            out_redirect,
   output logic [XLEN-1:0] out_target,
   output logic            out_illegal
);

   localparam logic [2:0] K_OP     = 3'd0;
   localparam logic [2:0] K_OP_IMM = 3'd1;
   localparam logic [2:0] K_LUI    = 3'd2;
   localparam logic [2:0] K_AUIPC  = 3'd3;
   localparam logic [2:0] K_BRANCH = 3'd4;
   localparam logic [2:0] K_JAL    = 3'd5;
   localparam logic [2:0] K_JALR   = 3'd6;
   localparam logic [2:0] K_ILL    = 3'd7;

   logic            d_valid;
   logic [2:0]      d_kind;
   logic [2:0]      d_funct3;
   logic            d_funct7b5;
   logic [4:0]      d_rd;
   logic [XLEN-1:0] d_pc, d_rs1, d_rs2, d_imm;

   // Valid/ready: a beat moves when valid & ready are both high in the same cycle;
   // the producer holds its payload stable while valid & !ready.
   logic r_adv, in_fire, out_fire, kill, r_load;
   assign r_adv    = !out_valid | out_ready;
   assign in_ready = !d_valid | r_adv;
   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;
   assign kill     = out_fire & out_redirect;
   assign r_load   = d_valid & !kill;

   always_comb begin
      alu_s1  = '0;
      alu_s2  = '0;
      alu_op  = 3'd0;
      alu_sub = 1'b0;
      alu_sra = 1'b0;
      case (d_kind)
         K_OP: begin
            alu_s1  = d_rs1;
            alu_s2  = d_rs2;
            alu_op  = d_funct3;
            alu_sub = d_funct7b5 & (d_funct3 == 3'd0);
            alu_sra = d_funct7b5;
         end
         K_OP_IMM: begin
            alu_s1  = d_rs1;
            alu_s2  = d_imm;
            alu_op  = d_funct3;
            alu_sra = d_funct7b5 & (d_funct3 == 3'd5);
         end
         K_LUI:   alu_s2 = d_imm;
         K_AUIPC: begin
            alu_s1 = d_pc;
            alu_s2 = d_imm;
         end
         K_BRANCH: begin
            alu_s1  = d_rs1;
            alu_s2  = d_rs2;
            alu_sub = 1'b1;
         end
         K_JAL, K_JALR: begin
            alu_s1 = d_pc;
            alu_s2 = XLEN'(4);
         end
         default: ;
      endcase
   end

   logic is_branch, bad_branch, taken;
   logic res_we, res_redirect, res_illegal;
   logic [XLEN-1:0] res_result, res_target, tgt_base, tgt_sum;

   assign is_branch  = (d_kind == K_BRANCH);
   assign bad_branch = is_branch & (d_funct3[2:1] == 2'b01);

   always_comb begin
      taken = 1'b0;
      case (d_funct3)
         3'd0:    taken = alu_eq;
         3'd1:    taken = !alu_eq;
         3'd4:    taken = alu_lt;
         3'd5:    taken = !alu_lt;
         3'd6:    taken = alu_ltu;
         3'd7:    taken = !alu_ltu;
         default: taken = 1'b0;
      endcase
   end

   // Private target adder keeps the ALU free for the link value (pc+4).
   assign tgt_base = (d_kind == K_JALR) ? d_rs1 : d_pc;
   assign tgt_sum  = tgt_base + d_imm;

   assign res_illegal  = (d_kind == K_ILL) | bad_branch;
   assign res_redirect = (d_kind == K_JAL) | (d_kind == K_JALR) | (is_branch & !bad_branch & taken);
   assign res_we       = !is_branch & (d_kind != K_ILL) & (d_rd != 5'd0);
   assign res_result   = (is_branch | (d_kind == K_ILL)) ? '0 : alu_out;
   assign res_target   = !res_redirect ? '0
                       : (d_kind == K_JALR) ? {tgt_sum[XLEN-1:1], 1'b0} : tgt_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_valid    <= 1'b0;
         d_kind     <= 3'd0;
         d_funct3   <= 3'd0;
         d_funct7b5 <= 1'b0;
         d_rd       <= 5'd0;
         d_pc       <= '0;
         d_rs1      <= '0;
         d_rs2      <= '0;
         d_imm      <= '0;
      end else if (flush || kill) begin
         d_valid <= 1'b0;
      end else if (in_fire) begin
         d_valid    <= 1'b1;
         d_kind     <= in_kind;
         d_funct3   <= in_funct3;
         d_funct7b5 <= in_funct7b5;
         d_rd       <= in_rd;
         d_pc       <= in_pc;
         d_rs1      <= in_rs1;
         d_rs2      <= in_rs2;
         d_imm      <= in_imm;
      end else if (r_adv) begin
         d_valid <= 1'b0;
      end
   end

   // An emptied result register is zeroed so idle outputs read as 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_rd       <= 5'd0;
         out_we       <= 1'b0;
         out_result   <= '0;
         out_redirect <= 1'b0;
         out_target   <= '0;
         out_illegal  <= 1'b0;
      end else if (flush) begin
         out_valid    <= 1'b0;
         out_rd       <= 5'd0;
         out_we       <= 1'b0;
         out_result   <= '0;
         out_redirect <= 1'b0;
         out_target   <= '0;
         out_illegal  <= 1'b0;
      end else if (r_adv) begin
         out_valid    <= r_load;
         out_rd       <= r_load ? d_rd : 5'd0;
         out_we       <= r_load & res_we;
         out_result   <= r_load ? res_result : '0;
         out_redirect <= r_load & res_redirect;
         out_target   <= r_load ? res_target : '0;
         out_illegal  <= r_load & res_illegal;
      end
   end

endmodule

// File: tb/tb_alu_ex_stage.sv
// Bench for alu_ex_stage: behavioural ALU, ISA-level reference queue, directed and random steps.
module tb_alu_ex_stage;

   localparam int XLEN = 32;
   localparam int EW   = 3 + 5 + 2 * XLEN;

   logic            clk, rst_n, flush, in_valid, in_ready;
   logic [2:0]      in_kind, in_funct3;
   logic            in_funct7b5;
   logic [4:0]      in_rd;
   logic [XLEN-1:0] in_pc, in_rs1, in_rs2, in_imm;
   logic [XLEN-1:0] alu_s1, alu_s2, alu_out;
   logic [2:0]      alu_op;
   logic            alu_sub, alu_sra, alu_eq, alu_lt, alu_ltu;
   logic            out_valid, out_ready, out_we, out_redirect, out_illegal;
   logic [4:0]      out_rd;
   logic [XLEN-1:0] out_result, out_target;

   alu_ex_stage #(.XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_funct3(in_funct3),
      .in_funct7b5(in_funct7b5), .in_rd(in_rd), .in_pc(in_pc), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_imm(in_imm),
      .alu_s1(alu_s1), .alu_s2(alu_s2), .alu_op(alu_op), .alu_sub(alu_sub), .alu_sra(alu_sra),
      .alu_out(alu_out), .alu_eq(alu_eq), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
      .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_we(out_we),
      .out_result(out_result), .out_redirect(out_redirect), .out_target(out_target),
      .out_illegal(out_illegal)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ALU attached to the stage
   always_comb begin
      alu_out = '0;
      case (alu_op)
         3'd0: if (alu_sub) alu_out = alu_s1 - alu_s2; else alu_out = alu_s1 + alu_s2;
         3'd1: alu_out = alu_s1 << alu_s2[4:0];
         3'd2: alu_out = ($signed(alu_s1) < $signed(alu_s2)) ? 32'd1 : 32'd0;
         3'd3: alu_out = (alu_s1 < alu_s2) ? 32'd1 : 32'd0;
         3'd4: alu_out = alu_s1 ^ alu_s2;
         3'd5: if (alu_sra) alu_out = $signed(alu_s1) >>> alu_s2[4:0];
               else alu_out = alu_s1 >> alu_s2[4:0];
         3'd6: alu_out = alu_s1 | alu_s2;
         default: alu_out = alu_s1 & alu_s2;
      endcase
   end
   assign alu_eq  = (alu_s1 == alu_s2);
   assign alu_lt  = ($signed(alu_s1) < $signed(alu_s2));
   assign alu_ltu = (alu_s1 < alu_s2);

   // scoreboard
   logic [EW-1:0]   exp_q[$];
   logic [XLEN-1:0] got_q[$];
   int n_cmp = 0;
   int n_mis = 0;
   logic last_in_fire;
   int n_acc;

   // Instruction semantics: packed {illegal, redirect, we, rd, result, target}
   function automatic logic [EW-1:0] ref_exec(input logic [2:0] kind, input logic [2:0] f3,
         input logic f7, input logic [4:0] rd, input logic [XLEN-1:0] pc, rs1, rs2, imm);
      logic [XLEN-1:0] b, res, tgt;
      logic redir, ill, tk, we;
      res = '0; tgt = '0; redir = 1'b0; ill = 1'b0; tk = 1'b0;
      b = (kind == 3'd0) ? rs2 : imm;
      case (kind)
         3'd0, 3'd1: begin
            case (f3)
               3'd0: if (kind == 3'd0 && f7) res = rs1 - b; else res = rs1 + b;
               3'd1: res = rs1 << b[4:0];
               3'd2: res = ($signed(rs1) < $signed(b)) ? 32'd1 : 32'd0;
               3'd3: res = (rs1 < b) ? 32'd1 : 32'd0;
               3'd4: res = rs1 ^ b;
               3'd5: if (f7) res = $signed(rs1) >>> b[4:0]; else res = rs1 >> b[4:0];
               3'd6: res = rs1 | b;
               default: res = rs1 & b;
            endcase
         end
         3'd2: res = imm;
         3'd3: res = pc + imm;
         3'd4: begin
            case (f3)
               3'd0: tk = (rs1 == rs2);
               3'd1: tk = (rs1 != rs2);
               3'd4: tk = ($signed(rs1) < $signed(rs2));
               3'd5: tk = ($signed(rs1) >= $signed(rs2));
               3'd6: tk = (rs1 < rs2);
               3'd7: tk = (rs1 >= rs2);
               default: ill = 1'b1;
            endcase
            if (tk) begin redir = 1'b1; tgt = pc + imm; end
         end
         3'd5: begin res = pc + 4; redir = 1'b1; tgt = pc + imm; end
         3'd6: begin res = pc + 4; redir = 1'b1; tgt = (rs1 + imm) & ~32'd1; end
         default: ill = 1'b1;
      endcase
      we = (kind != 3'd4) && (kind != 3'd7) && (rd != 5'd0);
      return {ill, redir, we, rd, res, tgt};
   endfunction

   task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outs();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_rd", out_rd, 0);
      chk("rst_out_we", out_we, 0);
      chk("rst_out_result", out_result, 0);
      chk("rst_out_redirect", out_redirect, 0);
      chk("rst_out_target", out_target, 0);
      chk("rst_out_illegal", out_illegal, 0);
      chk("rst_in_ready", in_ready, 1);
   endtask

   // driver tasks
   task automatic set_in(input logic [2:0] k, input logic [2:0] f3, input logic f7,
         input logic [4:0] rd, input logic [XLEN-1:0] pc, rs1, rs2, imm);
      in_valid = 1'b1; in_kind = k; in_funct3 = f3; in_funct7b5 = f7; in_rd = rd;
      in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   // One clock: check at the falling edge, update the reference, return #1 after the rising edge.
   task automatic cycle();
      logic in_fire, out_fire, kill;
      logic [EW-1:0] head;
      @(negedge clk);
      chk("in_ready", in_ready, !(exp_q.size() == 2 && !out_ready));
      if (exp_q.size() == 0) chk("empty_out_valid", out_valid, 0);
      if (exp_q.size() == 2) chk("full_out_valid", out_valid, 1);
      if (out_valid) begin
         if (exp_q.size() == 0) chk("out_has_ref", EW'(exp_q.size()), 1);
         else chk("out_fields", {out_illegal, out_redirect, out_we, out_rd, out_result, out_target},
                  exp_q[0]);
      end
      in_fire  = in_valid & in_ready;
      out_fire = out_valid & out_ready;
      last_in_fire = in_fire;
      if (out_fire) got_q.push_back(out_result);
      if (flush) begin
         exp_q.delete();
      end else begin
         kill = 1'b0;
         if (out_fire && exp_q.size() > 0) begin
            head = exp_q.pop_front();
            kill = head[EW-2];
         end
         if (kill) exp_q.delete();
         else if (in_fire)
            exp_q.push_back(ref_exec(in_kind, in_funct3, in_funct7b5, in_rd, in_pc,
                                     in_rs1, in_rs2, in_imm));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      in_valid = 1'b0; in_kind = '0; in_funct3 = '0; in_funct7b5 = 1'b0; in_rd = '0;
      in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
      #12;
      chk_reset_outs();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // OP sub with two-edge latency
      set_in(3'd0, 3'd0, 1'b1, 5'd3, 32'h40, 32'd5, 32'd7, 32'd0);
      cycle(); idle();
      chk("t1_alu_sub", alu_sub, 1);
      chk("t1_alu_s1", alu_s1, 5);
      chk("t1_alu_s2", alu_s2, 7);
      chk("t1_not_yet_out", out_valid, 0);
      cycle();
      chk("t1_out_valid", out_valid, 1);
      chk("t1_result", out_result, 32'hFFFF_FFFE);
      chk("t1_we", out_we, 1);
      chk("t1_redirect", out_redirect, 0);
      cycle();

      // BLT taken, younger instructions killed
      set_in(3'd4, 3'd4, 1'b0, 5'd0, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0);
      cycle();
      set_in(3'd1, 3'd0, 1'b0, 5'd9, 32'h104, 32'h55, 32'd0, 32'd1);
      cycle();
      chk("t2_redirect", out_redirect, 1);
      chk("t2_target", out_target, 32'hF0);
      chk("t2_we", out_we, 0);
      set_in(3'd1, 3'd0, 1'b0, 5'd10, 32'h108, 32'h66, 32'd0, 32'd1);
      cycle(); idle();
      chk("t2_killed_a", out_valid, 0);
      cycle();
      chk("t2_killed_b", out_valid, 0);

      // JALR, then JALR to x0
      set_in(3'd6, 3'd0, 1'b0, 5'd1, 32'h200, 32'h1003, 32'd0, 32'h10);
      cycle(); idle(); cycle();
      chk("t3_result", out_result, 32'h204);
      chk("t3_target", out_target, 32'h1012);
      chk("t3_redirect", out_redirect, 1);
      chk("t3_we", out_we, 1);
      cycle();
      set_in(3'd6, 3'd0, 1'b0, 5'd0, 32'h200, 32'h1003, 32'd0, 32'h10);
      cycle(); idle(); cycle();
      chk("t3_we_x0", out_we, 0);
      chk("t3_target_x0", out_target, 32'h1012);
      cycle();

      // Backpressure with four ADDIs
      got_q.delete();
      out_ready = 1'b0;
      n_acc = 0;
      for (int c = 0; c < 3; c++) begin
         set_in(3'd1, 3'd0, 1'b0, 5'd5, 32'h300, XLEN'(n_acc), 32'd0, 32'd1);
         cycle();
         if (last_in_fire) n_acc++;
      end
      chk("t4_accepts_stalled", n_acc, 2);
      chk("t4_in_ready_low", in_ready, 0);
      chk("t4_held_result", out_result, 1);
      out_ready = 1'b1;
      for (int c = 0; c < 20 && n_acc < 4; c++) begin
         set_in(3'd1, 3'd0, 1'b0, 5'd5, 32'h300, XLEN'(n_acc), 32'd0, 32'd1);
         cycle();
         if (last_in_fire) n_acc++;
      end
      idle();
      for (int c = 0; c < 4; c++) cycle();
      chk("t4_count", got_q.size(), 4);
      for (int k = 0; k < 4 && k < got_q.size(); k++) chk("t4_order", got_q[k], k + 1);

      // Illegal branch and illegal kind
      set_in(3'd4, 3'd2, 1'b0, 5'd4, 32'h400, 32'd1, 32'd1, 32'h20);
      cycle();
      set_in(3'd7, 3'd0, 1'b0, 5'd4, 32'h404, 32'd1, 32'd1, 32'h20);
      cycle(); idle();
      chk("t5_br_illegal", out_illegal, 1);
      chk("t5_br_we", out_we, 0);
      chk("t5_br_redirect", out_redirect, 0);
      cycle();
      chk("t5_k7_illegal", out_illegal, 1);
      chk("t5_k7_we", out_we, 0);
      cycle();

      // Flush with both stages full
      out_ready = 1'b0;
      set_in(3'd1, 3'd0, 1'b0, 5'd6, 32'h500, 32'd9, 32'd0, 32'd1);
      cycle(); cycle();
      chk("t5_full", in_ready, 0);
      flush = 1'b1;
      cycle();
      flush = 1'b0; idle();
      chk("t5_flush_out_valid", out_valid, 0);
      chk("t5_flush_in_ready", in_ready, 1);
      out_ready = 1'b1;
      cycle(); cycle();

      // Reset mid-stream
      set_in(3'd1, 3'd0, 1'b0, 5'd7, 32'h600, 32'd1, 32'd0, 32'd1);
      cycle();
      set_in(3'd1, 3'd0, 1'b0, 5'd8, 32'h604, 32'd2, 32'd0, 32'd1);
      cycle(); idle();
      #2 rst_n = 1'b0;
      #1 chk_reset_outs();
      exp_q.delete();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      set_in(3'd1, 3'd0, 1'b0, 5'd4, 32'h0, 32'h10, 32'd0, 32'h20);
      cycle(); idle();
      chk("t6_latency_early", out_valid, 0);
      cycle();
      chk("t6_latency_out", out_valid, 1);
      chk("t6_result", out_result, 32'h30);
      cycle();

      // Random traffic against the reference queue
      for (int c = 0; c < 500; c++) begin
         in_valid    = ($urandom_range(0, 3) != 0);
         in_kind     = 3'($urandom_range(0, 7));
         in_funct3   = 3'($urandom_range(0, 7));
         in_funct7b5 = 1'($urandom_range(0, 1));
         in_rd       = 5'($urandom_range(0, 31));
         in_pc       = $urandom & ~32'd3;
         in_rs1      = ($urandom_range(0, 1) == 1) ? XLEN'($urandom_range(0, 3)) : $urandom;
         in_rs2      = ($urandom_range(0, 1) == 1) ? XLEN'($urandom_range(0, 3)) : $urandom;
         in_imm      = ($urandom_range(0, 1) == 1) ? XLEN'($urandom_range(0, 31)) : $urandom;
         out_ready   = ($urandom_range(0, 3) != 0);
         flush       = ($urandom_range(0, 31) == 0);
         cycle();
      end
      flush = 1'b0; idle(); out_ready = 1'b1;
      for (int c = 0; c < 10; c++) cycle();
      chk("drain_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/alu_ex_stage.md
Name: alu_ex_stage

Overview:
- Execute-stage front end that sits between instruction decode and the ALU.
- Accepts decoded instructions over a valid/ready handshake and registers them. It drives the ALU operand and control inputs from that register, then consumes the ALU result and comparison flags.
- Registers writeback data plus branch/jump redirect information into an output stage with its own valid/ready handshake.
- Two-entry pipeline: D-register (operands) and R-register (result). Full throughput; backpressure propagates.

Parameters:
XLEN, 32, datapath width; must match the ALU instance.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of both stages
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage can accept this cycle
in_kind  in  3  0 OP, 1 OP_IMM, 2 LUI, 3 AUIPC, 4 BRANCH, 5 JAL, 6 JALR, 7 illegal
in_funct3  in  3  instruction funct3
in_funct7b5  in  1  instruction bit 30
in_rd  in  5  destination register
in_pc  in  XLEN  instruction address
in_rs1  in  XLEN  rs1 value
in_rs2  in  XLEN  rs2 value
in_imm  in  XLEN  sign-extended immediate, already in final form
alu_s1  out  XLEN  ALU operand 1
alu_s2  out  XLEN  ALU operand 2
alu_op  out  3  ALU op select
alu_sub  out  1  ALU subtract
alu_sra  out  1  ALU arithmetic shift
alu_out  in  XLEN  ALU result
alu_eq  in  1  ALU s1==s2
alu_lt  in  1  ALU signed s1<s2
alu_ltu  in  1  ALU unsigned s1<s2
out_valid  out  1  result register holds an instruction
out_ready  in  1  writeback accepts
out_rd  out  5  destination register
out_we  out  1  register-file write enable
out_result  out  XLEN  writeback data
out_redirect  out  1  fetch must redirect
out_target  out  XLEN  redirect address
out_illegal  out  1  instruction was illegal

Behaviour:
- Reset (rst_n low, asynchronous): d_valid=0, out_valid=0, and all data registers 0. Consequently every out_* is 0 and in_ready=1 after reset.
- Handshakes:
  - r_adv = !out_valid | out_ready.
  - in_ready = !d_valid | r_adv.
  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
  - The out_* outputs stay stable while out_valid & !out_ready.
- Latency: instruction accepted at edge k appears on out_* after edge k+1. Throughput is one per cycle with no bubbles while out_ready=1.
- The ALU drive is purely combinational from the D-register, giving zero cycles to the ALU. The ALU result is captured into the R-register on the r_adv edge when d_valid=1.
- Operand and control mapping (D-register fields):
  - OP: s1=rs1, s2=rs2, op=funct3, sub=funct7b5&(funct3==0), sra=funct7b5.
  - OP_IMM: s1=rs1, s2=imm, op=funct3, sub=0, sra=funct7b5&(funct3==5).
  - LUI: s1=0, s2=imm, op=0.
  - AUIPC: s1=pc, s2=imm, op=0.
  - BRANCH: s1=rs1, s2=rs2, op=0, sub=1.
  - JAL/JALR: s1=pc, s2=4, op=0.
  - illegal: all ALU inputs 0.
- Result:
  - out_result=alu_out for all kinds; for BRANCH and illegal, out_result=0.
  - out_we=1 for OP, OP_IMM, LUI, AUIPC, JAL, JALR, but forced 0 when rd==0; out_we=0 for BRANCH and illegal.
- Branch decision by funct3:
  - 0 eq, 1 !eq, 4 lt, 5 !lt, 6 ltu, 7 !ltu.
  - funct3 2 or 3 is illegal: no redirect, out_illegal=1.
- Target:
  - BRANCH/JAL: pc+imm.
  - JALR: (rs1+imm) with bit0 cleared.
  - Computed by a private XLEN-bit adder; wraps modulo 2^XLEN.
  - out_target=0 when there is no redirect.
- Redirect: JAL=1, JALR=1, BRANCH=taken, otherwise 0.
- Wrong-path kill: on an out transfer with out_redirect=1, d_valid is cleared at that edge. Any instruction transferred in on the same edge is discarded.
- flush=1: d_valid=0 and out_valid=0 at the edge, and any in transfer that cycle is dropped. flush has priority over all other events.
- Simultaneous in transfer and D→R advance: the D-register reloads with the new instruction; no loss.
- Mid-operation reset: state is cleared immediately and outputs are 0 while rst_n=0.

Test Plan:
1. OP sub: rs1=5, rs2=7, funct3=0, funct7b5=1, rd=3, out_ready=1 → alu_sub=1 while in D; two edges after presentation: out_result=0xFFFFFFFE, out_we=1, out_redirect=0.
2. BLT taken: rs1=0xFFFFFFFF, rs2=1, funct3=4, pc=0x100, imm=0xFFFFFFF0 → out_redirect=1, out_target=0xF0, out_we=0. A younger instruction accepted the same cycle as the redirect transfer never appears on out_valid.
3. JALR: pc=0x200, rs1=0x1003, imm=0x10, rd=1 → out_result=0x204, out_target=0x1012, out_redirect=1, out_we=1. Repeat with rd=0 → out_we=0.
4. Backpressure: stream 4 OP_IMM ADDI (imm=1, rs1=0..3) with out_ready=0 for 3 cycles → in_ready drops after 2 accepts and out_* stay stable. After release the results are 1,2,3,4 in order with no loss or duplication.
5. Illegal branch funct3=2 and kind=7 → out_illegal=1, out_we=0, out_redirect=0. flush asserted with both stages full → out_valid=0 and in_ready=1 next cycle.
6. Assert rst_n low mid-stream → out_valid=0 and all out_* = 0 immediately (before the next edge). After release, the first new instruction emerges after the normal latency.
